// File: rtl/digi_ota_pkg.sv
// Shared types and constants for the digital OTA calibration sequencer.
package digi_ota_pkg;

    // Sequencer states. SETTLE is reused for the settle before RUN; busy tells them apart.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_ACCUM  = 3'd2,
        ST_DECIDE = 3'd3,
        ST_RUN    = 3'd4
    } state_t;

    // Mid-scale trim code for the default 5-bit trim bus.
    localparam logic [4:0] TRIM_MID = 5'b10000;

    // Samples per majority decision.
    function automatic int avg_n(input int avg_log2);
        return 1 << avg_log2;
    endfunction

    // Mid-scale code (only the MSB set) for an arbitrary trim width.
    function automatic logic [31:0] trim_mid(input int trim_w);
        return 32'd1 << (trim_w - 1);
    endfunction

endpackage

// File: rtl/digi_ota_maj_acc.sv
// Majority accumulator: counts AVG_N samples of a bit and reports whether more
// than half were ones. Restarts on its own at each window end so RUN windows
// follow each other without a gap.
module digi_ota_maj_acc
    import digi_ota_pkg::*;
#(
    parameter int AVG_LOG2 = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,      // synchronous clear, wins over en
    input  logic en,       // accumulate sample this cycle
    input  logic sample,
    output logic done,     // this cycle takes the last sample of a window
    output logic maj,      // majority including this cycle's sample (valid with done)
    output logic maj_q     // majority of the last completed window
);

    localparam int AVG_N = avg_n(AVG_LOG2);

    logic [AVG_LOG2-1:0] smp_cnt;
    logic [AVG_LOG2:0]   ones;
    logic [AVG_LOG2:0]   ones_nxt;

    // Running ones-count with this cycle's sample and the window-end detect.
    always_comb begin
        ones_nxt = ones + {{AVG_LOG2{1'b0}}, sample};
        done     = en && (smp_cnt == AVG_LOG2'(AVG_N - 1));
        maj      = ones_nxt > (AVG_LOG2 + 1)'(AVG_N / 2);
    end

    // Sample counter and ones-count; the result is latched at each window end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            smp_cnt <= '0;
            ones    <= '0;
            maj_q   <= 1'b0;
        end else if (clr) begin
            smp_cnt <= '0;
            ones    <= '0;
        end else if (en) begin
            if (done) begin
                smp_cnt <= '0;
                ones    <= '0;
                maj_q   <= maj;
            end else begin
                smp_cnt <= smp_cnt + 1'b1;
                ones    <= ones_nxt;
            end
        end
    end

endmodule

// File: rtl/digi_ota_cal_seq.sv
// Sequencer for the inverter-based OTA/comparator slice: SAR offset calibration
// with inputs shorted, then a RUN mode producing majority-filtered decisions,
// with optional periodic recalibration.
//
// Handshake: start_cal is a single-cycle request, accepted whenever busy is low
// and dropped otherwise. cal_done and out_valid are single-cycle pulses with no
// back-pressure; out_bit is valid on the out_valid cycle and held afterwards.
module digi_ota_cal_seq
    import digi_ota_pkg::*;
#(
    parameter int TRIM_W       = 5,
    parameter int SETTLE_CYC   = 4,
    parameter int AVG_LOG2     = 3,
    parameter int RECAL_PERIOD = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_cal,
    input  logic              auto_recal,
    input  logic              cmp_in,
    output logic              ota_en,
    output logic              short_en,
    output logic [TRIM_W-1:0] trim_code,
    output logic              busy,
    output logic              cal_done,
    output logic              out_valid,
    output logic              out_bit,
    output logic [2:0]        state_dbg
);

    localparam logic [TRIM_W-1:0] TRIM_MID_W = TRIM_W'(trim_mid(TRIM_W));
    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int K_W   = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;
    localparam int REC_W = $clog2(RECAL_PERIOD + 1);

    state_t             state;
    logic               cmp_meta;
    logic               cmp_s;
    logic [SET_W-1:0]   settle_cnt;
    logic [K_W-1:0]     bit_k;
    logic [REC_W-1:0]   dec_cnt;
    logic [TRIM_W-1:0]  sar_next;
    logic               acc_clr;
    logic               acc_en;
    logic               acc_done;
    logic               acc_maj;
    logic               acc_maj_q;
    logic               cal_go;

    assign state_dbg = state;

    // Two-flop synchroniser for the asynchronous comparator output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_meta <= 1'b0;
            cmp_s    <= 1'b0;
        end else begin
            cmp_meta <= cmp_in;
            cmp_s    <= cmp_meta;
        end
    end

    // Accumulator runs only in ACCUM and RUN; everywhere else it is held cleared.
    always_comb begin
        acc_en  = (state == ST_ACCUM) || (state == ST_RUN);
        acc_clr = !acc_en;
    end

    digi_ota_maj_acc #(
        .AVG_LOG2 (AVG_LOG2)
    ) u_maj_acc (
        .clk    (clk),
        .rst    (rst),
        .clr    (acc_clr),
        .en     (acc_en),
        .sample (cmp_s),
        .done   (acc_done),
        .maj    (acc_maj),
        .maj_q  (acc_maj_q)
    );

    // SAR step: a majority of ones means the trial bit overshoots, so drop it;
    // then raise the next lower bit as the new trial.
    always_comb begin
        sar_next = trim_code;
        if (acc_maj_q) begin
            sar_next[bit_k] = 1'b0;
        end
        if (bit_k != '0) begin
            sar_next[bit_k - 1'b1] = 1'b1;
        end
    end

    // Calibration entry: a user request while idle/running, or the recal timer in RUN.
    always_comb begin
        cal_go = (start_cal && !busy) ||
                 ((state == ST_RUN) && auto_recal && (dec_cnt == REC_W'(RECAL_PERIOD)));
    end

    // Main sequencer FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            ota_en     <= 1'b0;
            short_en   <= 1'b0;
            trim_code  <= TRIM_MID_W;
            busy       <= 1'b0;
            cal_done   <= 1'b0;
            out_valid  <= 1'b0;
            out_bit    <= 1'b0;
            settle_cnt <= '0;
            bit_k      <= '0;
            dec_cnt    <= '0;
        end else begin
            cal_done  <= 1'b0;
            out_valid <= 1'b0;

            // A window that ends this cycle is always reported, even if calibration starts now.
            if ((state == ST_RUN) && acc_done) begin
                out_valid <= 1'b1;
                out_bit   <= acc_maj;
                if (dec_cnt != REC_W'(RECAL_PERIOD)) begin
                    dec_cnt <= dec_cnt + 1'b1;
                end
            end

            if (cal_go) begin
                state      <= ST_SETTLE;
                ota_en     <= 1'b1;
                short_en   <= 1'b1;
                trim_code  <= TRIM_MID_W;
                bit_k      <= K_W'(TRIM_W - 1);
                busy       <= 1'b1;
                settle_cnt <= '0;
                dec_cnt    <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_IDLE;
                    end
                    ST_SETTLE: begin
                        if (settle_cnt == SET_W'(SETTLE_CYC - 1)) begin
                            settle_cnt <= '0;
                            state      <= busy ? ST_ACCUM : ST_RUN;
                        end else begin
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                    end
                    ST_ACCUM: begin
                        if (acc_done) begin
                            state <= ST_DECIDE;
                        end
                    end
                    ST_DECIDE: begin
                        trim_code <= sar_next;
                        state     <= ST_SETTLE;
                        if (bit_k != '0) begin
                            bit_k <= bit_k - 1'b1;
                        end else begin
                            cal_done <= 1'b1;
                            short_en <= 1'b0;
                            busy     <= 1'b0;
                        end
                    end
                    ST_RUN: begin
                        state <= ST_RUN;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
